// File: rtl/aes_key_schedule.sv
// ---------------------------------------------------------------------------
// aes_key_schedule
//
// AES key expansion for 128/192/256-bit keys.  A key is accepted through a
// valid/ready handshake, then the expanded schedule is generated one 32-bit
// word per clock into an on-chip word store.  Once complete, any round key
// can be read combinationally by index.
//
// Ports
//   clk_i        in   1    clock; all state changes on the rising edge
//   reset_i      in   1    synchronous, active-high reset
//   key_v_i      in   1    new-key request (valid)
//   key_ready_o  out  1    a key can be accepted this cycle (ready)
//   key_i        in   256  cipher key, MSB-first (128b in [255:128],
//                          192b in [255:64])
//   key_size_i   in   2    0=128, 1=192, 2=256, 3=illegal; sampled on accept
//   done_o       out  1    schedule complete, round keys valid
//   rk_addr_i    in   4    round-key index 0..14
//   rk_o         out  128  selected round key (0 if index > Nr or not done)
//   err_o        out  1    one-cycle pulse after a rejected request
//
// Parameter
//   MAX_KEY_BITS  largest supported key size (128, 192 or 256); the word
//                 store holds 4*(MAX_KEY_BITS/32+7) words.
//
// Optional feature macro: AES_KEY_ZEROIZE_EN
//   Defined   : the word store is cleared on reset and on every accepted key
//               (one extra CLEAR cycle before expansion starts).
//   Undefined : the word store keeps its contents across reset; only the
//               control state is reset.
// ---------------------------------------------------------------------------

// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the
// affine transform.  The inverse is x^254 built from a short chain of
// squarings and multiplies (0 maps to 0 naturally).
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] acc;
    p   = 8'h00;
    acc = x;
    for (int b = 0; b < 8; b++) begin
      if (y[b]) p = p ^ acc;
      acc = xtime(acc);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  assign x2   = gf_mul(a, a);
  assign x3   = gf_mul(x2, a);
  assign x6   = gf_mul(x3, x3);
  assign x12  = gf_mul(x6, x6);
  assign x15  = gf_mul(x12, x3);
  assign x30  = gf_mul(x15, x15);
  assign x60  = gf_mul(x30, x30);
  assign x120 = gf_mul(x60, x60);
  assign x240 = gf_mul(x120, x120);
  assign x252 = gf_mul(x240, x12);
  assign inv  = gf_mul(x252, x2);

  assign s = inv
           ^ {inv[6:0], inv[7]}
           ^ {inv[5:0], inv[7:6]}
           ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]}
           ^ 8'h63;

endmodule

module aes_key_schedule #(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         key_v_i,
  output logic         key_ready_o,
  input  logic [255:0] key_i,
  input  logic [1:0]   key_size_i,
  output logic         done_o,
  input  logic [3:0]   rk_addr_i,
  output logic [127:0] rk_o,
  output logic         err_o
);

  localparam int WORDS = 4 * (MAX_KEY_BITS / 32 + 7);
  // Largest key-size code this build accepts (0, 1 or 2).
  localparam logic [1:0] MAX_KS = 2'((MAX_KEY_BITS - 128) / 64);

`ifdef AES_KEY_ZEROIZE_EN
  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE, S_CLEAR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;
`endif

  function automatic logic [3:0] nk_of(input logic [1:0] ks);
    case (ks)
      2'd1:    return 4'd6;
      2'd2:    return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] ks);
    case (ks)
      2'd1:    return 4'd12;
      2'd2:    return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  // Index of the final schedule word, 4*(Nr+1)-1.
  function automatic logic [5:0] last_of(input logic [1:0] ks);
    case (ks)
      2'd1:    return 6'd51;
      2'd2:    return 6'd59;
      default: return 6'd43;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // ------------------------------------------------------------------
  // Control state
  // ------------------------------------------------------------------
  state_t      state_reg, state_next;
  logic [1:0]  ks_reg;        // key-size code captured on accept
  logic [5:0]  i_reg;         // index of the word written next
  logic [3:0]  phase_reg;     // i mod Nk, tracked incrementally
  logic [7:0]  rcon_reg;
  logic        err_reg, err_next;
  logic        load_en;       // load w[0..Nk-1] (and clear, if enabled)
  logic        wr_en;         // write w[i] this edge

  logic        req_fire;
  logic        key_illegal;

  logic [31:0] w_mem [WORDS];

`ifdef AES_KEY_ZEROIZE_EN
  // The key is loaded one cycle after accept, so it must be held here.
  logic [255:0] key_reg;
  logic [255:0] load_key;
  logic [1:0]   load_ks;
  assign load_key = key_reg;
  assign load_ks  = ks_reg;
`else
  logic [255:0] load_key;
  logic [1:0]   load_ks;
  assign load_key = key_i;
  assign load_ks  = key_size_i;
`endif

  logic [3:0] load_nk;
  assign load_nk = nk_of(load_ks);

  assign key_ready_o = (state_reg == S_IDLE) || (state_reg == S_DONE);
  assign done_o      = (state_reg == S_DONE);
  assign err_o       = err_reg;

  assign req_fire    = key_v_i & key_ready_o;
  assign key_illegal = (key_size_i == 2'd3) || (key_size_i > MAX_KS);

  // Next-state and datapath strobes
  always_comb begin
    state_next = state_reg;
    err_next   = 1'b0;
    load_en    = 1'b0;
    wr_en      = 1'b0;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (req_fire) begin
          if (key_illegal) begin
            err_next = 1'b1;
          end else begin
`ifdef AES_KEY_ZEROIZE_EN
            state_next = S_CLEAR;
`else
            state_next = S_EXPAND;
            load_en    = 1'b1;
`endif
          end
        end
      end
`ifdef AES_KEY_ZEROIZE_EN
      S_CLEAR: begin
        load_en    = 1'b1;
        state_next = S_EXPAND;
      end
`endif
      S_EXPAND: begin
        wr_en = 1'b1;
        if (i_reg == last_of(ks_reg)) state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg <= S_IDLE;
      err_reg   <= 1'b0;
      ks_reg    <= 2'd0;
      i_reg     <= 6'd0;
      phase_reg <= 4'd0;
      rcon_reg  <= 8'h01;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
      if (req_fire && !key_illegal) ks_reg <= key_size_i;
      if (load_en) begin
        i_reg     <= {2'b00, load_nk};
        phase_reg <= 4'd0;
        rcon_reg  <= 8'h01;
      end else if (wr_en) begin
        i_reg     <= i_reg + 6'd1;
        phase_reg <= (phase_reg == nk_of(ks_reg) - 4'd1) ? 4'd0 : phase_reg + 4'd1;
        // Rcon is consumed on the i mod Nk == 0 word, then advances.
        if (phase_reg == 4'd0) rcon_reg <= xtime(rcon_reg);
      end
    end
  end

`ifdef AES_KEY_ZEROIZE_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      key_reg <= '0;
    end else if (req_fire && !key_illegal) begin
      key_reg <= key_i;
    end
  end
`endif

  // ------------------------------------------------------------------
  // Word generator
  // ------------------------------------------------------------------
  logic [31:0] prev_word;   // w[i-1]
  logic [31:0] back_word;   // w[i-Nk]
  logic [31:0] rot_word;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] temp_word;
  logic [31:0] new_word;
  logic        use_rot;
  logic        use_sub;

  assign prev_word = w_mem[i_reg - 6'd1];
  assign back_word = w_mem[i_reg - {2'b00, nk_of(ks_reg)}];
  assign rot_word  = {prev_word[23:0], prev_word[31:24]};
  assign use_rot   = (phase_reg == 4'd0);
  // AES-256 adds a plain SubWord halfway through each 8-word group.
  assign use_sub   = (ks_reg == 2'd2) && (phase_reg == 4'd4);
  // One shared set of S-boxes serves both SubWord cases.
  assign sub_in    = use_rot ? rot_word : prev_word;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      aes_sbox u_sbox (
        .a (sub_in[8*gi +: 8]),
        .s (sub_out[8*gi +: 8])
      );
    end
  endgenerate

  always_comb begin
    temp_word = prev_word;
    if (use_rot)      temp_word = sub_out ^ {rcon_reg, 24'h000000};
    else if (use_sub) temp_word = sub_out;
  end

  assign new_word = back_word ^ temp_word;

  // ------------------------------------------------------------------
  // Word store.  Writes are suppressed on a reset edge so an abandoned
  // schedule never lands a stray word.
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
`ifdef AES_KEY_ZEROIZE_EN
    if (reset_i) begin
      for (int j = 0; j < WORDS; j++) w_mem[j] <= '0;
    end else if (load_en) begin
      for (int j = 0; j < WORDS; j++) begin
        if (j < 8 && j < int'(load_nk)) w_mem[j] <= load_key[255 - 32*(j % 8) -: 32];
        else                            w_mem[j] <= '0;
      end
    end else if (wr_en) begin
      w_mem[i_reg] <= new_word;
    end
`else
    if (!reset_i) begin
      if (load_en) begin
        for (int j = 0; j < 8; j++) begin
          if (j < int'(load_nk)) w_mem[j] <= load_key[255 - 32*j -: 32];
        end
      end else if (wr_en) begin
        w_mem[i_reg] <= new_word;
      end
    end
`endif
  end

  // ------------------------------------------------------------------
  // Round-key read port
  // ------------------------------------------------------------------
  logic [5:0] rk_base;
  logic       rk_valid;

  assign rk_base  = {rk_addr_i, 2'b00};
  assign rk_valid = done_o && (rk_addr_i <= nr_of(ks_reg));

  always_comb begin
    rk_o = '0;
    if (rk_valid) begin
      rk_o = {w_mem[rk_base], w_mem[rk_base + 6'd1],
              w_mem[rk_base + 6'd2], w_mem[rk_base + 6'd3]};
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_aes_key_schedule
//
// Directed checks of the AES key schedule against FIPS-197 key-expansion
// vectors: latency, selected round keys, out-of-range reads, rejection,
// reset behaviour and input sampling.
// ---------------------------------------------------------------------------
module tb_aes_key_schedule;

`ifdef AES_KEY_ZEROIZE_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  localparam logic [127:0] RK128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RK192_0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RK192_12 = 128'ha4970a331a78dc09c418c271e3a41d5d;
  localparam logic [127:0] RK256_0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RK256_1  = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] RK256_14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

  logic         clk = 1'b0;
  logic         reset_i;
  logic         key_v_i;
  logic         key_ready_o;
  logic [255:0] key_i;
  logic [1:0]   key_size_i;
  logic         done_o;
  logic [3:0]   rk_addr_i;
  logic [127:0] rk_o;
  logic         err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aes_key_schedule #(.MAX_KEY_BITS(256)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .key_v_i     (key_v_i),
    .key_ready_o (key_ready_o),
    .key_i       (key_i),
    .key_size_i  (key_size_i),
    .done_o      (done_o),
    .rk_addr_i   (rk_addr_i),
    .rk_o        (rk_o),
    .err_o       (err_o)
  );

  // Present a key for one accept edge; returns 1 time unit after that edge.
  task automatic apply_key(input logic [255:0] k, input logic [1:0] s);
    key_v_i    = 1'b1;
    key_i      = k;
    key_size_i = s;
    @(posedge clk);
    #1;
    key_v_i = 1'b0;
  endtask

  // Counts edges until done_o is seen high, bounded at 200 edges.
  task automatic wait_done(output int n);
    n = 0;
    while (!done_o && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset;
    reset_i = 1'b1; key_v_i = 1'b0; key_i = '0; key_size_i = 2'd0; rk_addr_i = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b0;
    total++; if (done_o !== 1'b0)      begin bad++; $display("FAIL reset_done: got %b want 0", done_o); end
    total++; if (key_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", key_ready_o); end
    total++; if (err_o !== 1'b0)       begin bad++; $display("FAIL reset_err: got %b want 0", err_o); end
    total++; if (rk_o !== 128'h0)      begin bad++; $display("FAIL reset_rk: got %h want 0", rk_o); end
  endtask

  task automatic test_aes128;
    int n;
    apply_key(K128, 2'd0);
    total++; if (key_ready_o !== 1'b0) begin bad++; $display("FAIL a128_busy: got %b want 0", key_ready_o); end
    wait_done(n);
    total++; if (n != 40 + EXTRA) begin bad++; $display("FAIL a128_latency: got %0d want %0d", n, 40 + EXTRA); end
    rk_addr_i = 4'd0;  #1;
    total++; if (rk_o !== RK128_0)  begin bad++; $display("FAIL a128_rk0: got %h want %h", rk_o, RK128_0); end
    rk_addr_i = 4'd1;  #1;
    total++; if (rk_o !== RK128_1)  begin bad++; $display("FAIL a128_rk1: got %h want %h", rk_o, RK128_1); end
    rk_addr_i = 4'd10; #1;
    total++; if (rk_o !== RK128_10) begin bad++; $display("FAIL a128_rk10: got %h want %h", rk_o, RK128_10); end
    rk_addr_i = 4'd11; #1;
    total++; if (rk_o !== 128'h0)   begin bad++; $display("FAIL a128_rk11: got %h want 0", rk_o); end
  endtask

  // Illegal size while in DONE: pulse error, keep schedule.
  task automatic test_illegal_in_done;
    apply_key(K256, 2'd3);
    total++; if (err_o !== 1'b1)  begin bad++; $display("FAIL done_ill_err: got %b want 1", err_o); end
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL done_ill_done: got %b want 1", done_o); end
    @(posedge clk); #1;
    total++; if (err_o !== 1'b0)  begin bad++; $display("FAIL done_ill_pulse: got %b want 0", err_o); end
    rk_addr_i = 4'd10; #1;
    total++; if (rk_o !== RK128_10) begin bad++; $display("FAIL done_ill_keep: got %h want %h", rk_o, RK128_10); end
  endtask

  // Restart from DONE with a 192-bit key.
  task automatic test_aes192;
    int n;
    apply_key(K192, 2'd1);
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL a192_restart: got %b want 0", done_o); end
    wait_done(n);
    total++; if (n != 46 + EXTRA) begin bad++; $display("FAIL a192_latency: got %0d want %0d", n, 46 + EXTRA); end
    rk_addr_i = 4'd0;  #1;
    total++; if (rk_o !== RK192_0)  begin bad++; $display("FAIL a192_rk0: got %h want %h", rk_o, RK192_0); end
    rk_addr_i = 4'd12; #1;
    total++; if (rk_o !== RK192_12) begin bad++; $display("FAIL a192_rk12: got %h want %h", rk_o, RK192_12); end
    rk_addr_i = 4'd13; #1;
    total++; if (rk_o !== 128'h0)   begin bad++; $display("FAIL a192_rk13: got %h want 0", rk_o); end
  endtask

  task automatic test_aes256;
    int n;
    apply_key(K256, 2'd2);
    wait_done(n);
    total++; if (n != 52 + EXTRA) begin bad++; $display("FAIL a256_latency: got %0d want %0d", n, 52 + EXTRA); end
    rk_addr_i = 4'd0;  #1;
    total++; if (rk_o !== RK256_0)  begin bad++; $display("FAIL a256_rk0: got %h want %h", rk_o, RK256_0); end
    rk_addr_i = 4'd1;  #1;
    total++; if (rk_o !== RK256_1)  begin bad++; $display("FAIL a256_rk1: got %h want %h", rk_o, RK256_1); end
    rk_addr_i = 4'd14; #1;
    total++; if (rk_o !== RK256_14) begin bad++; $display("FAIL a256_rk14: got %h want %h", rk_o, RK256_14); end
    rk_addr_i = 4'd15; #1;
    total++; if (rk_o !== 128'h0)   begin bad++; $display("FAIL a256_rk15: got %h want 0", rk_o); end
  endtask

  // Illegal size from IDLE.
  task automatic test_illegal_idle;
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    apply_key(K128, 2'd3);
    total++; if (err_o !== 1'b1)       begin bad++; $display("FAIL idle_ill_err: got %b want 1", err_o); end
    total++; if (key_ready_o !== 1'b1) begin bad++; $display("FAIL idle_ill_ready: got %b want 1", key_ready_o); end
    total++; if (done_o !== 1'b0)      begin bad++; $display("FAIL idle_ill_done: got %b want 0", done_o); end
    @(posedge clk); #1;
    total++; if (err_o !== 1'b0)       begin bad++; $display("FAIL idle_ill_pulse: got %b want 0", err_o); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (done_o !== 1'b0 || key_ready_o !== 1'b1) begin
      bad++; $display("FAIL idle_ill_state: got done=%b ready=%b want done=0 ready=1", done_o, key_ready_o);
    end
  endtask

  // Reset 20 edges into an AES-256 expansion, then a clean AES-128 run.
  task automatic test_mid_reset;
    int n;
    apply_key(K256, 2'd2);
    repeat (19) @(posedge clk);
    #1;
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    total++; if (done_o !== 1'b0 || key_ready_o !== 1'b1 || err_o !== 1'b0) begin
      bad++; $display("FAIL midrst_state: got done=%b ready=%b err=%b want 0 1 0", done_o, key_ready_o, err_o);
    end
    apply_key(K128, 2'd0);
    wait_done(n);
    total++; if (n != 40 + EXTRA) begin bad++; $display("FAIL midrst_latency: got %0d want %0d", n, 40 + EXTRA); end
    rk_addr_i = 4'd10; #1;
    total++; if (rk_o !== RK128_10) begin bad++; $display("FAIL midrst_rk10: got %h want %h", rk_o, RK128_10); end
    rk_addr_i = 4'd1; #1;
    total++; if (rk_o !== RK128_1)  begin bad++; $display("FAIL midrst_rk1: got %h want %h", rk_o, RK128_1); end
  endtask

  // Reset and a legal request on the same edge: reset wins.
  task automatic test_reset_priority;
    reset_i = 1'b1;
    apply_key(K256, 2'd2);
    reset_i = 1'b0;
    total++; if (done_o !== 1'b0 || key_ready_o !== 1'b1) begin
      bad++; $display("FAIL rstprio_state: got done=%b ready=%b want 0 1", done_o, key_ready_o);
    end
    repeat (60) @(posedge clk);
    #1;
    total++; if (done_o !== 1'b0 || key_ready_o !== 1'b1) begin
      bad++; $display("FAIL rstprio_idle: got done=%b ready=%b want 0 1", done_o, key_ready_o);
    end
  endtask

  // A second request during expansion is ignored.
  task automatic test_ignore_mid_expand;
    int n;
    apply_key(K128, 2'd0);
    repeat (5) @(posedge clk);
    #1;
    key_v_i = 1'b1; key_i = K256; key_size_i = 2'd2;
    @(posedge clk); #1;
    key_v_i = 1'b0;
    total++; if (err_o !== 1'b0 || key_ready_o !== 1'b0) begin
      bad++; $display("FAIL ignore_state: got err=%b ready=%b want 0 0", err_o, key_ready_o);
    end
    wait_done(n);
    total++; if (n + 6 != 40 + EXTRA) begin bad++; $display("FAIL ignore_latency: got %0d want %0d", n + 6, 40 + EXTRA); end
    rk_addr_i = 4'd10; #1;
    total++; if (rk_o !== RK128_10) begin bad++; $display("FAIL ignore_rk10: got %h want %h", rk_o, RK128_10); end
    rk_addr_i = 4'd14; #1;
    total++; if (rk_o !== 128'h0)   begin bad++; $display("FAIL ignore_rk14: got %h want 0", rk_o); end
  endtask

  // key_i / key_size_i changed right after accept must not matter.
  task automatic test_sample_on_accept;
    int n;
    apply_key(K128, 2'd0);
    key_i = K256; key_size_i = 2'd2;
    wait_done(n);
    total++; if (n != 40 + EXTRA) begin bad++; $display("FAIL sample_latency: got %0d want %0d", n, 40 + EXTRA); end
    rk_addr_i = 4'd0; #1;
    total++; if (rk_o !== RK128_0)  begin bad++; $display("FAIL sample_rk0: got %h want %h", rk_o, RK128_0); end
    rk_addr_i = 4'd10; #1;
    total++; if (rk_o !== RK128_10) begin bad++; $display("FAIL sample_rk10: got %h want %h", rk_o, RK128_10); end
  endtask

  initial begin
    test_reset();
    test_aes128();
    test_illegal_in_done();
    test_aes192();
    test_aes256();
    test_illegal_idle();
    test_mid_reset();
    test_reset_priority();
    test_ignore_mid_expand();
    test_sample_on_accept();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
